// File: rtl/mips_multicycle_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS main controller: opcodes, ALUOP
// codes (must stay in step with the ALU controller CNRL decode), mux codes, states.
package mips_multicycle_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [2:0] ALUOP_ADD   = 3'b000;
  localparam logic [2:0] ALUOP_SUB   = 3'b001;
  localparam logic [2:0] ALUOP_FUNCT = 3'b010;
  localparam logic [2:0] ALUOP_SLT   = 3'b011;
  localparam logic [2:0] ALUOP_AND   = 3'b100;
  localparam logic [2:0] ALUOP_OR    = 3'b101;
  localparam logic [2:0] ALUOP_XOR   = 3'b110;

  localparam logic [1:0] ALUB_REG    = 2'b00;
  localparam logic [1:0] ALUB_FOUR   = 2'b01;
  localparam logic [1:0] ALUB_IMM    = 2'b10;
  localparam logic [1:0] ALUB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_FETCH  = 4'd1,
    ST_DECODE = 4'd2,
    ST_MEMADR = 4'd3,
    ST_MEMRD  = 4'd4,
    ST_MEMWB  = 4'd5,
    ST_MEMWR  = 4'd6,
    ST_EXEC_R = 4'd7,
    ST_EXEC_I = 4'd8,
    ST_ALUWB  = 4'd9,
    ST_BRANCH = 4'd10,
    ST_JUMP   = 4'd11,
    ST_TRAP   = 4'd12
  } state_e;

  // Per-instruction details captured in DECODE so later states ignore OPCODE.
  typedef struct packed {
    logic       store;
    logic       bne;
    logic [2:0] ialu_op;
  } opsel_t;

endpackage

// File: rtl/mips_multicycle_ctrl_opcode_class.sv
// Combinational OPCODE decoder: one-hot instruction class plus the I-type ALUOP.
module mips_opcode_class
  import mips_multicycle_ctrl_pkg::*;
(
  input  logic [5:0] opcode,
  output logic       is_mem,
  output logic       is_rtype,
  output logic       is_ialu,
  output logic       is_branch,
  output logic       is_jump,
  output logic       is_illegal,
  output logic       is_store,
  output logic       is_bne,
  output logic [2:0] ialu_op
);

  always_comb begin
    is_mem     = 1'b0;
    is_rtype   = 1'b0;
    is_ialu    = 1'b0;
    is_branch  = 1'b0;
    is_jump    = 1'b0;
    is_illegal = 1'b0;
    is_store   = 1'b0;
    is_bne     = 1'b0;
    ialu_op    = ALUOP_ADD;
    case (opcode)
      OP_LW:    is_mem = 1'b1;
      OP_SW:    begin is_mem = 1'b1; is_store = 1'b1; end
      OP_RTYPE: is_rtype = 1'b1;
      OP_ADDI,
      OP_ADDIU: is_ialu = 1'b1;
      OP_SLTI:  begin is_ialu = 1'b1; ialu_op = ALUOP_SLT; end
      OP_ANDI:  begin is_ialu = 1'b1; ialu_op = ALUOP_AND; end
      OP_ORI:   begin is_ialu = 1'b1; ialu_op = ALUOP_OR;  end
      OP_XORI:  begin is_ialu = 1'b1; ialu_op = ALUOP_XOR; end
      OP_BEQ:   is_branch = 1'b1;
      OP_BNE:   begin is_branch = 1'b1; is_bne = 1'b1; end
      OP_J:     is_jump = 1'b1;
      default:  is_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS main control FSM: sequences fetch/decode/execute/memory/writeback
// and drives every datapath enable, mux select and the ALUOP fed to the ALU controller.
//
// state   | meaning
// IDLE    | after reset, all controls low
// FETCH   | read instruction at PC, PC+4; load IR/PC when memory ready
// DECODE  | compute branch target, latch instruction class
// MEMADR  | ALUOut = A + sign-extended imm
// MEMRD   | load data read at ALUOut
// MEMWB   | write MDR into rt
// MEMWR   | store B at ALUOut
// EXEC_R  | R-type ALU operation
// EXEC_I  | I-type ALU operation
// ALUWB   | write ALUOut into rd/rt
// BRANCH  | compare A-B, conditionally load PC from ALUOut
// JUMP    | load PC with jump target
// TRAP    | illegal opcode, parked until reset
module mips_multicycle_ctrl
  import mips_multicycle_ctrl_pkg::*;
(
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [5:0]  OPCODE,
  input  logic        MEM_READY,
  input  logic        ZERO,
  output logic        IOR_D,
  output logic        MEM_RD,
  output logic        MEM_WR,
  output logic        IR_WRITE,
  output logic        PC_WRITE,
  output logic        REG_DST,
  output logic        MEM_TO_REG,
  output logic        REG_WRITE,
  output logic        ALU_SRC_A,
  output logic [1:0]  ALU_SRC_B,
  output logic [1:0]  PC_SRC,
  output logic [2:0]  ALUOP,
  output logic        ILLEGAL,
  output logic [31:0] RETIRED
);

  state_e      state_q, state_d;
  opsel_t      opsel_q, opsel_d;
  logic        reg_dst_q, reg_dst_d;
  logic        illegal_q, illegal_d;
  logic [31:0] retired_q, retired_d;
  logic        retire;

  logic       cls_mem, cls_rtype, cls_ialu, cls_branch, cls_jump, cls_illegal;
  logic       cls_store, cls_bne;
  logic [2:0] cls_ialu_op;

  mips_opcode_class u_opcode_class (
    .opcode     (OPCODE),
    .is_mem     (cls_mem),
    .is_rtype   (cls_rtype),
    .is_ialu    (cls_ialu),
    .is_branch  (cls_branch),
    .is_jump    (cls_jump),
    .is_illegal (cls_illegal),
    .is_store   (cls_store),
    .is_bne     (cls_bne),
    .ialu_op    (cls_ialu_op)
  );

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q   <= ST_IDLE;
      opsel_q   <= '0;
      reg_dst_q <= 1'b0;
      illegal_q <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      opsel_q   <= opsel_d;
      reg_dst_q <= reg_dst_d;
      illegal_q <= illegal_d;
      retired_q <= retired_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    opsel_d    = opsel_q;
    reg_dst_d  = reg_dst_q;
    illegal_d  = illegal_q;
    retire     = 1'b0;
    IOR_D      = 1'b0;
    MEM_RD     = 1'b0;
    MEM_WR     = 1'b0;
    IR_WRITE   = 1'b0;
    PC_WRITE   = 1'b0;
    REG_DST    = 1'b0;
    MEM_TO_REG = 1'b0;
    REG_WRITE  = 1'b0;
    ALU_SRC_A  = 1'b0;
    ALU_SRC_B  = ALUB_REG;
    PC_SRC     = PCSRC_ALU;
    ALUOP      = ALUOP_ADD;
    case (state_q)
      ST_IDLE: state_d = ST_FETCH;
      ST_FETCH: begin
        MEM_RD    = 1'b1;
        ALU_SRC_B = ALUB_FOUR;
        if (MEM_READY) begin
          IR_WRITE = 1'b1;
          PC_WRITE = 1'b1;
          state_d  = ST_DECODE;
        end
      end
      ST_DECODE: begin
        ALU_SRC_B = ALUB_IMM_SH;
        opsel_d   = '{store: cls_store, bne: cls_bne, ialu_op: cls_ialu_op};
        if (cls_mem)         state_d = ST_MEMADR;
        else if (cls_rtype)  state_d = ST_EXEC_R;
        else if (cls_ialu)   state_d = ST_EXEC_I;
        else if (cls_branch) state_d = ST_BRANCH;
        else if (cls_jump)   state_d = ST_JUMP;
        else begin
          state_d   = ST_TRAP;
          illegal_d = cls_illegal;
        end
      end
      ST_MEMADR: begin
        ALU_SRC_A = 1'b1;
        ALU_SRC_B = ALUB_IMM;
        state_d   = opsel_q.store ? ST_MEMWR : ST_MEMRD;
      end
      ST_MEMRD: begin
        IOR_D  = 1'b1;
        MEM_RD = 1'b1;
        if (MEM_READY) state_d = ST_MEMWB;
      end
      ST_MEMWB: begin
        REG_WRITE  = 1'b1;
        MEM_TO_REG = 1'b1;
        retire     = 1'b1;
        state_d    = ST_FETCH;
      end
      ST_MEMWR: begin
        IOR_D  = 1'b1;
        MEM_WR = 1'b1;
        if (MEM_READY) begin
          retire  = 1'b1;
          state_d = ST_FETCH;
        end
      end
      ST_EXEC_R: begin
        ALU_SRC_A = 1'b1;
        ALUOP     = ALUOP_FUNCT;
        reg_dst_d = 1'b1;
        state_d   = ST_ALUWB;
      end
      ST_EXEC_I: begin
        ALU_SRC_A = 1'b1;
        ALU_SRC_B = ALUB_IMM;
        ALUOP     = opsel_q.ialu_op;
        reg_dst_d = 1'b0;
        state_d   = ST_ALUWB;
      end
      ST_ALUWB: begin
        REG_WRITE = 1'b1;
        REG_DST   = reg_dst_q;
        retire    = 1'b1;
        state_d   = ST_FETCH;
      end
      ST_BRANCH: begin
        ALU_SRC_A = 1'b1;
        ALUOP     = ALUOP_SUB;
        PC_SRC    = PCSRC_ALUOUT;
        PC_WRITE  = opsel_q.bne ? ~ZERO : ZERO;
        retire    = 1'b1;
        state_d   = ST_FETCH;
      end
      ST_JUMP: begin
        PC_SRC   = PCSRC_JUMP;
        PC_WRITE = 1'b1;
        retire   = 1'b1;
        state_d  = ST_FETCH;
      end
      ST_TRAP: state_d = ST_TRAP;
      default: state_d = ST_IDLE;
    endcase
    retired_d = retired_q + {31'd0, retire};
  end

  assign ILLEGAL = illegal_q;
  assign RETIRED = retired_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed bench for mips_multicycle_ctrl: a per-cycle vector table plus
// hand sequences for reset during a memory wait and the illegal-opcode trap.
module tb_mips_multicycle_ctrl;

  logic        CLK;
  logic        RST_N;
  logic [5:0]  OPCODE;
  logic        MEM_READY;
  logic        ZERO;
  logic        IOR_D, MEM_RD, MEM_WR, IR_WRITE, PC_WRITE, REG_DST;
  logic        MEM_TO_REG, REG_WRITE, ALU_SRC_A, ILLEGAL;
  logic [1:0]  ALU_SRC_B, PC_SRC;
  logic [2:0]  ALUOP;
  logic [31:0] RETIRED;

  mips_multicycle_ctrl dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .OPCODE     (OPCODE),
    .MEM_READY  (MEM_READY),
    .ZERO       (ZERO),
    .IOR_D      (IOR_D),
    .MEM_RD     (MEM_RD),
    .MEM_WR     (MEM_WR),
    .IR_WRITE   (IR_WRITE),
    .PC_WRITE   (PC_WRITE),
    .REG_DST    (REG_DST),
    .MEM_TO_REG (MEM_TO_REG),
    .REG_WRITE  (REG_WRITE),
    .ALU_SRC_A  (ALU_SRC_A),
    .ALU_SRC_B  (ALU_SRC_B),
    .PC_SRC     (PC_SRC),
    .ALUOP      (ALUOP),
    .ILLEGAL    (ILLEGAL),
    .RETIRED    (RETIRED)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // {IOR_D, MEM_RD, MEM_WR, IR_WRITE, PC_WRITE, REG_DST, MEM_TO_REG, REG_WRITE,
  //  ALU_SRC_A, ALU_SRC_B[1:0], PC_SRC[1:0], ALUOP[2:0], ILLEGAL}
  logic [16:0] ctl;
  assign ctl = {IOR_D, MEM_RD, MEM_WR, IR_WRITE, PC_WRITE, REG_DST, MEM_TO_REG,
                REG_WRITE, ALU_SRC_A, ALU_SRC_B, PC_SRC, ALUOP, ILLEGAL};

  typedef struct {
    logic [5:0]  op;
    logic        rdy;
    logic        zero;
    logic [16:0] ctl;
    logic [31:0] ret;
  } vec_t;

  vec_t vq[$];
  int   checks = 0;
  int   errors = 0;

  logic [16:0] C_IDLE, C_FETCH_W, C_FETCH, C_DECODE, C_MEMADR, C_MEMRD, C_MEMWB;
  logic [16:0] C_MEMWR, C_EXEC_R, C_EXEC_ORI, C_EXEC_SLTI, C_ALUWB_R, C_ALUWB_I;
  logic [16:0] C_BR_TAKEN, C_BR_NOT, C_JUMP, C_TRAP;

  localparam logic [5:0] X = 6'b111111;

  function automatic logic [16:0] mk(input logic ior, rd, wr, irw, pcw, rdst, m2r, rw, asa,
                                     input logic [1:0] asb, pcs, input logic [2:0] aop,
                                     input logic ill);
    return {ior, rd, wr, irw, pcw, rdst, m2r, rw, asa, asb, pcs, aop, ill};
  endfunction

  task automatic add(input logic [5:0] op, input logic rdy, input logic zero,
                     input logic [16:0] c, input logic [31:0] ret);
    vec_t v;
    v.op = op; v.rdy = rdy; v.zero = zero; v.ctl = c; v.ret = ret;
    vq.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    //            ior rd wr irw pcw rdst m2r rw asa asb    pcs    aop     ill
    C_IDLE      = '0;
    C_FETCH_W   = mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 3'b000, 0);
    C_FETCH     = mk(0, 1, 0, 1, 1, 0, 0, 0, 0, 2'b01, 2'b00, 3'b000, 0);
    C_DECODE    = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 3'b000, 0);
    C_MEMADR    = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 3'b000, 0);
    C_MEMRD     = mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 3'b000, 0);
    C_MEMWB     = mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 2'b00, 2'b00, 3'b000, 0);
    C_MEMWR     = mk(1, 0, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 3'b000, 0);
    C_EXEC_R    = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 3'b010, 0);
    C_EXEC_ORI  = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 3'b101, 0);
    C_EXEC_SLTI = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 3'b011, 0);
    C_ALUWB_R   = mk(0, 0, 0, 0, 0, 1, 0, 1, 0, 2'b00, 2'b00, 3'b000, 0);
    C_ALUWB_I   = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 3'b000, 0);
    C_BR_TAKEN  = mk(0, 0, 0, 0, 1, 0, 0, 0, 1, 2'b00, 2'b01, 3'b001, 0);
    C_BR_NOT    = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b01, 3'b001, 0);
    C_JUMP      = mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 2'b00, 2'b10, 3'b000, 0);
    C_TRAP      = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 3'b000, 1);

    // One row per clock cycle; OPCODE only carries the real value in DECODE.
    add(X, 1, 0, C_IDLE, 0);
    // lw, no waits
    add(X, 1, 0, C_FETCH, 0);      add(6'b100011, 1, 0, C_DECODE, 0);
    add(X, 1, 0, C_MEMADR, 0);     add(X, 1, 0, C_MEMRD, 0);
    add(X, 1, 0, C_MEMWB, 0);
    // sw, three wait cycles in MEMWR
    add(X, 1, 0, C_FETCH, 1);      add(6'b101011, 1, 0, C_DECODE, 1);
    add(X, 0, 0, C_MEMADR, 1);     add(X, 0, 0, C_MEMWR, 1);
    add(X, 0, 0, C_MEMWR, 1);      add(X, 0, 0, C_MEMWR, 1);
    add(X, 1, 0, C_MEMWR, 1);
    // R-type, MEM_READY low outside FETCH must not stall
    add(X, 1, 1, C_FETCH, 2);      add(6'b000000, 0, 1, C_DECODE, 2);
    add(X, 0, 1, C_EXEC_R, 2);     add(X, 0, 1, C_ALUWB_R, 2);
    // ori
    add(X, 1, 0, C_FETCH, 3);      add(6'b001101, 1, 0, C_DECODE, 3);
    add(X, 1, 0, C_EXEC_ORI, 3);   add(X, 1, 0, C_ALUWB_I, 3);
    // slti
    add(X, 1, 0, C_FETCH, 4);      add(6'b001010, 1, 0, C_DECODE, 4);
    add(X, 1, 0, C_EXEC_SLTI, 4);  add(X, 1, 0, C_ALUWB_I, 4);
    // beq taken (ZERO=1), then bne not taken (ZERO=1)
    add(X, 1, 1, C_FETCH, 5);      add(6'b000100, 1, 1, C_DECODE, 5);
    add(X, 1, 1, C_BR_TAKEN, 5);
    add(X, 1, 1, C_FETCH, 6);      add(6'b000101, 1, 1, C_DECODE, 6);
    add(X, 1, 1, C_BR_NOT, 6);
    // j
    add(X, 1, 0, C_FETCH, 7);      add(6'b000010, 1, 0, C_DECODE, 7);
    add(X, 1, 0, C_JUMP, 7);
    // lw with one wait in FETCH and one in MEMRD
    add(X, 0, 0, C_FETCH_W, 8);    add(X, 1, 0, C_FETCH, 8);
    add(6'b100011, 1, 0, C_DECODE, 8);
    add(X, 1, 0, C_MEMADR, 8);     add(X, 0, 0, C_MEMRD, 8);
    add(X, 1, 0, C_MEMRD, 8);      add(X, 1, 0, C_MEMWB, 8);
    add(X, 0, 0, C_FETCH_W, 9);

    RST_N = 1'b0; OPCODE = '0; MEM_READY = 1'b0; ZERO = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    #1;
    chk("reset_ctl", {15'd0, ctl}, 32'd0);
    chk("reset_retired", RETIRED, 32'd0);
    RST_N = 1'b1;

    foreach (vq[i]) begin
      OPCODE = vq[i].op; MEM_READY = vq[i].rdy; ZERO = vq[i].zero;
      #1;
      chk($sformatf("row%0d_ctl", i), {15'd0, ctl}, {15'd0, vq[i].ctl});
      chk($sformatf("row%0d_retired", i), RETIRED, vq[i].ret);
      @(negedge CLK);
    end

    // Reset while a load is waiting in MEMRD.
    OPCODE = 6'b100011; MEM_READY = 1'b1; ZERO = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    @(negedge CLK);
    MEM_READY = 1'b0;
    #1;
    chk("memrd_wait_ctl", {15'd0, ctl}, {15'd0, C_MEMRD});
    RST_N = 1'b0;
    @(negedge CLK);
    #1;
    chk("midrd_reset_ctl", {15'd0, ctl}, 32'd0);
    chk("midrd_reset_retired", RETIRED, 32'd0);
    RST_N = 1'b1;
    @(negedge CLK);
    #1;
    chk("post_reset_fetch", {15'd0, ctl}, {15'd0, C_FETCH_W});

    // Illegal opcode parks in TRAP regardless of inputs.
    OPCODE = 6'b111111; MEM_READY = 1'b1;
    @(negedge CLK);
    #1;
    chk("trap_decode", {15'd0, ctl}, {15'd0, C_DECODE});
    @(negedge CLK);
    for (int i = 0; i < 100; i++) begin
      MEM_READY = i[0]; ZERO = i[1]; OPCODE = i[5:0];
      #1;
      chk($sformatf("trap_c%0d_ctl", i), {15'd0, ctl}, {15'd0, C_TRAP});
      chk($sformatf("trap_c%0d_retired", i), RETIRED, 32'd0);
      @(negedge CLK);
    end
    RST_N = 1'b0;
    @(negedge CLK);
    #1;
    chk("trap_reset_ctl", {15'd0, ctl}, 32'd0);
    RST_N = 1'b1;
    @(negedge CLK);
    #1;
    chk("trap_reset_fetch", {15'd0, ctl}, {15'd0, C_FETCH});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
